// File: rtl/lb_seq_pkg.sv
// Shared types and limits for the lb_seq_master local-bus sequencer.
package lb_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2
    } lb_seq_state_t;

    localparam int LB_READ_PIPE_MAX = 8;
    localparam int LB_AW            = 24;
    localparam int LB_DW            = 32;

    typedef struct packed {
        logic [LB_AW-1:0] addr;
        logic [LB_DW-1:0] data;
    } lb_seq_rsp_t;

endpackage

// File: rtl/lb_seq_rsp_fifo.sv
// Response FIFO for lb_seq_master: synchronous, power-of-two depth, occupancy exported so the
// issuing side can reserve a slot for every read before its strobe goes out.
module lb_seq_rsp_fifo
    import lb_seq_pkg::*;
#(
    parameter int W     = LB_AW + LB_DW,
    parameter int DEPTH = 8,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] rdata,
    output logic [PW:0]  count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + (PW+1)'(push) - (PW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign valid = (count_q != '0);
    assign rdata = valid ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/lb_seq_master.sv
// lb_seq_master: turns a write/read command stream into local-bus cycles and returns read data
// through a response FIFO. Define LB_SEQ_BURST_EN to honour cmd_len as a burst length.
module lb_seq_master
    import lb_seq_pkg::*;
#(
    parameter int AW        = 24,
    parameter int DW        = 32,
    parameter int READ_PIPE = 3,
    parameter int RSP_DEPTH = 8
) (
    input  logic          lb_clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    input  logic [7:0]    cmd_len,
    output logic          lb_strobe,
    output logic          lb_write,
    output logic          lb_rd,
    output logic [AW-1:0] lb_addr,
    output logic [DW-1:0] lb_data_out,
    input  logic [DW-1:0] lb_din,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [AW-1:0] rsp_addr,
    output logic          busy
);

    localparam int CW = $clog2(RSP_DEPTH) + 1;

    if (READ_PIPE < 1 || READ_PIPE > LB_READ_PIPE_MAX || RSP_DEPTH < READ_PIPE) begin : g_bad_cfg
        $error("lb_seq_master: READ_PIPE must be 1..8 and RSP_DEPTH >= READ_PIPE");
    end

    lb_seq_state_t        state_q, state_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 lb_strobe_q, lb_strobe_d;
    logic                 lb_write_q, lb_write_d;
    logic                 lb_rd_q, lb_rd_d;
    logic [AW-1:0]        lb_addr_q, lb_addr_d;
    logic [DW-1:0]        lb_data_out_q, lb_data_out_d;
    logic                 wr_q, wr_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [DW-1:0]        data_q, data_d;
    logic [READ_PIPE-1:0] pipe_vld_q, pipe_vld_d;
    logic [AW-1:0]        pipe_addr_q [READ_PIPE];
    logic [AW-1:0]        pipe_addr_d [READ_PIPE];
    logic [CW-1:0]        rsp_count;
    logic [AW+DW-1:0]     rsp_word;
    logic                 credit_ok;
    int                   inflight;
    logic                 beat_try, beat_wr;
    logic [AW-1:0]        beat_addr;
    logic [DW-1:0]        beat_data;
`ifdef LB_SEQ_BURST_EN
    logic [8:0]           left_q, left_d, beat_left;
`else
    logic                 unused_len;
    assign unused_len = ^cmd_len;
`endif

    // A read may go out only if a FIFO slot is still free after every read already on the bus lands.
    always_comb begin
        inflight = (lb_strobe_q && lb_rd_q) ? 1 : 0;
        for (int i = 0; i < READ_PIPE; i++) begin
            inflight += int'(pipe_vld_q[i]);
        end
        credit_ok = (RSP_DEPTH - int'(rsp_count)) > inflight;
    end

    always_comb begin
        pipe_vld_d[0]  = lb_strobe_q && lb_rd_q;
        pipe_addr_d[0] = lb_addr_q;
        for (int i = 1; i < READ_PIPE; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_addr_d[i] = pipe_addr_q[i-1];
        end
    end

    always_comb begin
        state_d       = state_q;
        wr_d          = wr_q;
        addr_d        = addr_q;
        data_d        = data_q;
        lb_strobe_d   = 1'b0;
        lb_write_d    = 1'b0;
        lb_rd_d       = 1'b0;
        lb_addr_d     = lb_addr_q;
        lb_data_out_d = lb_data_out_q;
        beat_try      = 1'b0;
        beat_wr       = wr_q;
        beat_addr     = addr_q;
        beat_data     = data_q;
`ifdef LB_SEQ_BURST_EN
        left_d        = left_q;
        beat_left     = left_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    beat_try  = 1'b1;
                    beat_wr   = cmd_write;
                    beat_addr = cmd_addr;
                    beat_data = cmd_data;
                    wr_d      = cmd_write;
                    data_d    = cmd_data;
`ifdef LB_SEQ_BURST_EN
                    beat_left = {1'b0, cmd_len} + 9'd1;
`endif
                end
            end
            ISSUE: begin
`ifdef LB_SEQ_BURST_EN
                if (left_q != '0) begin
                    beat_try = 1'b1;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            STALL:   beat_try = 1'b1;
            default: state_d  = IDLE;
        endcase

        if (beat_try) begin
            if (beat_wr || credit_ok) begin
                lb_strobe_d = 1'b1;
                lb_write_d  = beat_wr;
                lb_rd_d     = !beat_wr;
                lb_addr_d   = beat_addr;
                if (beat_wr) begin
                    lb_data_out_d = beat_data;
                end
                addr_d  = beat_addr + AW'(1);
                state_d = ISSUE;
`ifdef LB_SEQ_BURST_EN
                left_d  = beat_left - 9'd1;
`endif
            end else begin
                addr_d  = beat_addr;
                state_d = STALL;
`ifdef LB_SEQ_BURST_EN
                left_d  = beat_left;
`endif
            end
        end
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge lb_clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            lb_strobe_q   <= 1'b0;
            lb_write_q    <= 1'b0;
            lb_rd_q       <= 1'b0;
            lb_addr_q     <= '0;
            lb_data_out_q <= '0;
            pipe_vld_q    <= '0;
`ifdef LB_SEQ_BURST_EN
            left_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            lb_strobe_q   <= lb_strobe_d;
            lb_write_q    <= lb_write_d;
            lb_rd_q       <= lb_rd_d;
            lb_addr_q     <= lb_addr_d;
            lb_data_out_q <= lb_data_out_d;
            pipe_vld_q    <= pipe_vld_d;
`ifdef LB_SEQ_BURST_EN
            left_q        <= left_d;
`endif
        end
        wr_q        <= wr_d;
        addr_q      <= addr_d;
        data_q      <= data_d;
        pipe_addr_q <= pipe_addr_d;
    end

    lb_seq_rsp_fifo #(
        .W     (AW + DW),
        .DEPTH (RSP_DEPTH),
        .PW    (CW - 1)
    ) u_rsp_fifo (
        .clk   (lb_clk),
        .reset (reset),
        .push  (pipe_vld_q[READ_PIPE-1]),
        .wdata ({pipe_addr_q[READ_PIPE-1], lb_din}),
        .pop   (rsp_ready),
        .valid (rsp_valid),
        .rdata (rsp_word),
        .count (rsp_count)
    );

    assign {rsp_addr, rsp_data} = rsp_word;
    assign cmd_ready   = cmd_ready_q;
    assign lb_strobe   = lb_strobe_q;
    assign lb_write    = lb_write_q;
    assign lb_rd       = lb_rd_q;
    assign lb_addr     = lb_addr_q;
    assign lb_data_out = lb_data_out_q;
    assign busy        = (state_q != IDLE) || (lb_strobe_q && lb_rd_q) || (|pipe_vld_q);

endmodule
